// File: rtl/t05_huff_pkg.sv
// Shared types and constants for the team-05 Huffman compressor.
// Phase selector codes, phase status codes and scan candidate bundle.
package t05_huff_pkg;

    localparam int         NBINS     = 256;
    localparam int         FRAME_W   = 18;
    localparam logic [7:0] EOF_BYTE  = 8'h1A;

    typedef enum logic [3:0] {
        PH_IDLE = 4'd0,
        PH_HG   = 4'd1,
        PH_FLV  = 4'd2,
        PH_HT   = 4'd3,
        PH_CB   = 4'd4,
        PH_TL   = 4'd5
    } phase_e;

    typedef enum logic [3:0] {
        FIN_BUSY = 4'd0,
        FIN_OK   = 4'd1,
        FIN_ERR  = 4'd2
    } fin_e;

    typedef struct packed {
        logic        valid;
        logic [8:0]  idx;
        logic [63:0] w;
    } cand_t;

    function automatic logic [3:0] fin_of(input logic ok);
        return ok ? FIN_OK : FIN_ERR;
    endfunction

endpackage

// File: rtl/t05_huffman_if.sv
// Controller-facing bundle of the Huffman sequencer.
// master = external controller, slave = sequencer.
interface t05_huffman_if;

    logic [3:0]  en_state;
    logic [7:0]  read_out;
    logic [63:0] compVal;
    logic [63:0] nulls;
    logic        SRAM_finished;
    logic        miso;
    logic        mosi;
    logic [3:0]  fin_state_HG;
    logic [3:0]  fin_state_FLV;
    logic [3:0]  fin_state_HT;
    logic [3:0]  fin_state_CB;
    logic [3:0]  fin_state_TL;

    modport master (
        output en_state, read_out, compVal, nulls, SRAM_finished, miso,
        input  mosi, fin_state_HG, fin_state_FLV, fin_state_HT,
        input  fin_state_CB, fin_state_TL
    );

    modport slave (
        input  en_state, read_out, compVal, nulls, SRAM_finished, miso,
        output mosi, fin_state_HG, fin_state_FLV, fin_state_HT,
        output fin_state_CB, fin_state_TL
    );

endinterface

// File: rtl/t05_flv_scan.sv
// Finds the two smallest nonzero weights over 256 bins plus compVal.
// One bin per cycle, then one cycle for the compVal candidate (index 256).
module t05_flv_scan
    import t05_huff_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             run,
    input  logic [CNT_W-1:0] weight,
    input  logic [63:0]      comp_val,
    output logic [7:0]       rd_idx,
    output logic [3:0]       fin,
    output logic [8:0]       least1,
    output logic [8:0]       least2,
    output logic [63:0]      w1,
    output logic [63:0]      w2,
    output logic             err
);

    logic [8:0]  idx;
    logic [8:0]  cur;
    logic        step;
    logic [63:0] cand_w;
    cand_t       cand;
    cand_t       b1, b2;
    cand_t       b1_base, b2_base;
    cand_t       n1, n2;
    logic        ok;

    assign step    = start | (run & (fin == FIN_BUSY));
    assign cur     = start ? 9'd0 : idx;
    assign rd_idx  = cur[7:0];
    assign cand_w  = cur[8] ? comp_val : 64'(weight);
    assign cand    = '{valid: cand_w != 64'd0, idx: cur, w: cand_w};
    assign b1_base = start ? '0 : b1;
    assign b2_base = start ? '0 : b2;
    assign ok      = n1.valid & n2.valid;

    // Insert the current candidate; equal weights never displace earlier ones
    always_comb begin
        n1 = b1_base;
        n2 = b2_base;
        if (cand.valid && (!b1_base.valid || cand.w < b1_base.w)) begin
            n2 = b1_base;
            n1 = cand;
        end else if (cand.valid && (!b2_base.valid || cand.w < b2_base.w)) begin
            n2 = cand;
        end
    end

    // Scan state and published results; results change only when a scan completes
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx    <= '0;
            b1     <= '0;
            b2     <= '0;
            fin    <= FIN_BUSY;
            least1 <= '0;
            least2 <= '0;
            w1     <= '0;
            w2     <= '0;
            err    <= 1'b0;
        end else if (step) begin
            idx <= cur + 9'd1;
            b1  <= n1;
            b2  <= n2;
            fin <= FIN_BUSY;
            if (cur[8]) begin
                fin    <= fin_of(ok);
                err    <= ~ok;
                least1 <= ok ? n1.idx : 9'd0;
                least2 <= ok ? n2.idx : 9'd0;
                w1     <= ok ? n1.w : 64'd0;
                w2     <= ok ? n2.w : 64'd0;
            end
        end
    end

endmodule

// File: rtl/t05_huffman_top.sv
// Team-05 Huffman phase sequencer: histogram, least-pair search,
// tree node sum, one-bit codebook and serial frame emission.
module t05_huffman_top
    import t05_huff_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int MAX_CHARS = 255
) (
    input  logic          hwclk,
    input  logic          reset,
    t05_huffman_if.slave  bus
);

    logic [3:0]         en;
    logic [3:0]         prev_en;
    logic               entry;
    logic               sel_hg, sel_flv, sel_ht, sel_cb, sel_tl;
    logic               start_hg, start_flv, start_ht, start_cb, start_tl;
    logic               miso_q;

    logic [CNT_W-1:0]   hist [NBINS];
    logic [7:0]         hg_cnt;
    logic [7:0]         cnt_base;
    logic [8:0]         cnt_nxt;
    logic               hg_go;
    logic [3:0]         fin_hg;

    logic [7:0]         flv_idx;
    logic [3:0]         fin_flv;
    logic [8:0]         least1, least2;
    logic [63:0]        w1, w2;
    logic               flv_err;

    logic [63:0]        sum;
    logic [3:0]         fin_ht;

    logic               cb_step;
    logic               code_l1, code_l2;
    logic [1:0]         code_len;
    logic [3:0]         fin_cb;

    logic [FRAME_W-1:0] tl_sr;
    logic [4:0]         tl_cnt;
    logic               mosi_q;
    logic [3:0]         fin_tl;
    logic               unused_bits;

    assign en        = bus.en_state;
    assign entry     = en != prev_en;
    assign sel_hg    = en == PH_HG;
    assign sel_flv   = en == PH_FLV;
    assign sel_ht    = en == PH_HT;
    assign sel_cb    = en == PH_CB;
    assign sel_tl    = en == PH_TL;
    assign start_hg  = entry & sel_hg;
    assign start_flv = entry & sel_flv;
    assign start_ht  = entry & sel_ht;
    assign start_cb  = entry & sel_cb;
    assign start_tl  = entry & sel_tl;

    // Previous phase select for entry detection; miso is only captured
    always_ff @(posedge hwclk) begin
        if (!reset) begin
            prev_en <= PH_IDLE;
            miso_q  <= 1'b0;
        end else begin
            prev_en <= en;
            miso_q  <= bus.miso;
        end
    end

    assign hg_go    = sel_hg & (start_hg | (fin_hg == FIN_BUSY));
    assign cnt_base = start_hg ? 8'd0 : hg_cnt;
    assign cnt_nxt  = {1'b0, cnt_base} + 9'd1;

    // Histogram: count one byte per cycle until EOF or the byte limit
    always_ff @(posedge hwclk) begin
        if (!reset) begin
            for (int i = 0; i < NBINS; i++) hist[i] <= '0;
            hg_cnt <= '0;
            fin_hg <= FIN_BUSY;
        end else if (hg_go) begin
            fin_hg <= FIN_BUSY;
            hg_cnt <= cnt_base;
            if (bus.read_out == EOF_BYTE) begin
                fin_hg <= FIN_OK;
            end else begin
                if (!(&hist[bus.read_out]))
                    hist[bus.read_out] <= hist[bus.read_out] + 1'b1;
                hg_cnt <= cnt_nxt[7:0];
                if (cnt_nxt == 9'(MAX_CHARS))
                    fin_hg <= FIN_OK;
            end
        end
    end

    t05_flv_scan #(.CNT_W(CNT_W)) u_flv (
        .clk      (hwclk),
        .reset    (reset),
        .start    (start_flv),
        .run      (sel_flv),
        .weight   (hist[flv_idx]),
        .comp_val (bus.compVal),
        .rd_idx   (flv_idx),
        .fin      (fin_flv),
        .least1   (least1),
        .least2   (least2),
        .w1       (w1),
        .w2       (w2),
        .err      (flv_err)
    );

    // Tree node: latch the pair sum, then wait for the SRAM write handshake
    always_ff @(posedge hwclk) begin
        if (!reset) begin
            sum    <= '0;
            fin_ht <= FIN_BUSY;
        end else if (start_ht) begin
            sum    <= w1 + w2;
            fin_ht <= FIN_BUSY;
        end else if (sel_ht && fin_ht == FIN_BUSY && bus.SRAM_finished) begin
            fin_ht <= fin_of(bus.nulls != 64'd0);
        end
    end

    // Codebook: least1 gets 0, least2 gets 1, settled on the second cycle
    always_ff @(posedge hwclk) begin
        if (!reset) begin
            cb_step  <= 1'b0;
            code_l1  <= 1'b0;
            code_l2  <= 1'b0;
            code_len <= '0;
            fin_cb   <= FIN_BUSY;
        end else if (start_cb) begin
            cb_step <= 1'b0;
            fin_cb  <= FIN_BUSY;
        end else if (sel_cb && fin_cb == FIN_BUSY) begin
            if (!cb_step) begin
                cb_step <= 1'b1;
            end else begin
                code_l1  <= 1'b0;
                code_l2  <= 1'b1;
                code_len <= 2'd1;
                fin_cb   <= fin_of(~flv_err);
            end
        end
    end

    // Translate: shift the index pair out MSB first, idle line low
    always_ff @(posedge hwclk) begin
        if (!reset) begin
            tl_sr  <= '0;
            tl_cnt <= '0;
            mosi_q <= 1'b0;
            fin_tl <= FIN_BUSY;
        end else begin
            mosi_q <= 1'b0;
            if (start_tl) begin
                tl_sr  <= {least1, least2};
                tl_cnt <= '0;
                fin_tl <= FIN_BUSY;
            end else if (sel_tl && fin_tl == FIN_BUSY) begin
                if (tl_cnt < 5'(FRAME_W)) begin
                    mosi_q <= tl_sr[FRAME_W-1];
                    tl_sr  <= {tl_sr[FRAME_W-2:0], 1'b0};
                    tl_cnt <= tl_cnt + 5'd1;
                end else begin
                    fin_tl <= FIN_OK;
                end
            end
        end
    end

    assign unused_bits       = ^{miso_q, code_l1, code_l2, code_len};

    assign bus.mosi          = mosi_q;
    assign bus.fin_state_HG  = fin_hg;
    assign bus.fin_state_FLV = fin_flv;
    assign bus.fin_state_HT  = fin_ht;
    assign bus.fin_state_CB  = fin_cb;
    assign bus.fin_state_TL  = fin_tl;

endmodule

// File: tb/tb_t05_huffman_top.sv
// Randomized bench for t05_huffman_top against a phase-level model.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_t05_huffman_top;

    logic hwclk = 1'b0;
    logic reset;

    always #5 hwclk = ~hwclk;

    t05_huffman_if bus ();

    t05_huffman_top dut (
        .hwclk (hwclk),
        .reset (reset),
        .bus   (bus)
    );

    int nchk = 0;
    int nerr = 0;

    int          hm [256];
    logic [8:0]  m_l1, m_l2;
    logic [63:0] m_w1, m_w2;
    bit          m_err;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge hwclk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.en_state = 4'd0;
        bus.read_out = 8'd0;
        bus.compVal = 64'd0;
        bus.nulls = 64'd0;
        bus.SRAM_finished = 1'b0;
        bus.miso = 1'b0;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 256; k++) hm[k] = 0;
        m_l1 = 0; m_l2 = 0; m_w1 = 0; m_w2 = 0; m_err = 0;
        check("rst_hg", bus.fin_state_HG, 0);
        check("rst_flv", bus.fin_state_FLV, 0);
        check("rst_ht", bus.fin_state_HT, 0);
        check("rst_cb", bus.fin_state_CB, 0);
        check("rst_tl", bus.fin_state_TL, 0);
        check("rst_mosi", bus.mosi, 0);
    endtask

    task automatic run_hg(input logic [7:0] q[$]);
        int cnt = 0;
        bit done = 0;
        int bad = 0;
        bus.en_state = 4'd1;
        foreach (q[i]) begin
            if (done) break;
            bus.read_out = q[i];
            bus.miso = 1'($urandom);
            if (q[i] == 8'h1A) begin
                done = 1;
            end else begin
                if (hm[q[i]] < 255) hm[q[i]]++;
                cnt++;
                if (cnt == 255) done = 1;
            end
            tick();
            check(done ? "hg_done" : "hg_busy", bus.fin_state_HG, done ? 1 : 0);
        end
        for (int k = 0; k < 256; k++)
            if (int'(dut.hist[k]) != hm[k]) bad++;
        check("hist_bins", bad, 0);
    endtask

    function automatic logic [63:0] wt(input int k, input logic [63:0] cv);
        return (k < 256) ? 64'(hm[k]) : cv;
    endfunction

    task automatic run_flv(input logic [63:0] cv);
        int a = -1;
        int b = -1;
        for (int k = 0; k < 257; k++)
            if (wt(k, cv) != 0 && (a < 0 || wt(k, cv) < wt(a, cv))) a = k;
        for (int k = 0; k < 257; k++)
            if (k != a && wt(k, cv) != 0 && (b < 0 || wt(k, cv) < wt(b, cv))) b = k;
        m_err = (b < 0);
        m_l1 = m_err ? 9'd0 : 9'(a);
        m_l2 = m_err ? 9'd0 : 9'(b);
        m_w1 = m_err ? 64'd0 : wt(a, cv);
        m_w2 = m_err ? 64'd0 : wt(b, cv);
        bus.en_state = 4'd2;
        bus.compVal = cv;
        for (int i = 0; i < 256; i++) begin
            bus.miso = 1'($urandom);
            tick();
        end
        check("flv_busy", bus.fin_state_FLV, 0);
        tick();
        check("flv_fin", bus.fin_state_FLV, m_err ? 2 : 1);
        check("flv_l1", dut.least1, m_l1);
        check("flv_l2", dut.least2, m_l2);
    endtask

    task automatic run_ht(input logic [63:0] n, input int d);
        bus.en_state = 4'd3;
        bus.nulls = n;
        bus.SRAM_finished = (d == 0);
        if (d == 0) begin
            tick();
            check("ht_entry", bus.fin_state_HT, 0);
        end
        for (int i = 0; i < d; i++) begin
            tick();
            check("ht_wait", bus.fin_state_HT, 0);
        end
        check("ht_sum", dut.sum, m_w1 + m_w2);
        bus.SRAM_finished = 1'b1;
        tick();
        check("ht_fin", bus.fin_state_HT, (n != 0) ? 1 : 2);
        bus.SRAM_finished = 1'b0;
    endtask

    task automatic run_cb();
        bus.en_state = 4'd4;
        tick();
        tick();
        check("cb_busy", bus.fin_state_CB, 0);
        tick();
        check("cb_fin", bus.fin_state_CB, m_err ? 2 : 1);
    endtask

    task automatic run_tl();
        logic [17:0] got = '0;
        bus.en_state = 4'd5;
        tick();
        check("tl_start", bus.mosi, 0);
        for (int i = 0; i < 18; i++) begin
            bus.miso = 1'($urandom);
            tick();
            got = {got[16:0], bus.mosi};
            if (i == 17) check("tl_busy", bus.fin_state_TL, 0);
        end
        check("tl_frame", got, {m_l1, m_l2});
        tick();
        check("tl_fin", bus.fin_state_TL, 1);
        check("tl_idle", bus.mosi, 0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [63:0] cv;
        int mode, len;
        logic [7:0] sym;

        // reset then immediate EOF
        do_reset();
        q = {8'h1A};
        run_hg(q);

        // small stream, full phase chain
        do_reset();
        q = {8'h41, 8'h41, 8'h42, 8'h1A};
        run_hg(q);
        run_flv(64'd0);
        check("d2_l1", dut.least1, 9'h042);
        check("d2_l2", dut.least2, 9'h041);
        run_ht(64'd0, 0);
        check("d2_sum", dut.sum, 64'd3);
        run_cb();
        run_tl();

        // reset in the middle of TL
        bus.en_state = 4'd0;
        tick();
        bus.en_state = 4'd5;
        repeat (4) tick();
        check("tl_mid", bus.mosi, 1);
        reset = 1'b0;
        bus.miso = ~bus.miso;
        tick();
        check("mid_mosi", bus.mosi, 0);
        check("mid_hg", bus.fin_state_HG, 0);
        check("mid_flv", bus.fin_state_FLV, 0);
        check("mid_ht", bus.fin_state_HT, 0);
        check("mid_cb", bus.fin_state_CB, 0);
        check("mid_tl", bus.fin_state_TL, 0);
        reset = 1'b1;
        bus.en_state = 4'd0;
        for (int i = 0; i < 4; i++) begin
            bus.miso = ~bus.miso;
            tick();
            check("miso_mosi", bus.mosi, 0);
            check("miso_tl", bus.fin_state_TL, 0);
        end

        // empty histogram, slow SRAM handshake
        do_reset();
        run_flv(64'd0);
        run_ht(64'd500, 50);
        run_cb();

        // randomized chains
        for (int t = 0; t < 12; t++) begin
            do_reset();
            q = {};
            mode = $urandom_range(0, 3);
            case (mode)
                0: begin
                    len = $urandom_range(0, 20);
                    for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(8'h40, 8'h45)));
                    q.push_back(8'h1A);
                end
                1: begin
                    for (int i = 0; i < 300; i++) q.push_back(8'($urandom_range(8'h30, 8'h37)));
                end
                2: begin
                    len = $urandom_range(0, 30);
                    for (int i = 0; i < len; i++) q.push_back(8'($urandom));
                    q.push_back(8'h1A);
                end
                default: begin
                    len = $urandom_range(1, 5);
                    sym = 8'($urandom_range(8'h60, 8'h7F));
                    for (int i = 0; i < len; i++) q.push_back(sym);
                    q.push_back(8'h1A);
                end
            endcase
            run_hg(q);
            case ($urandom_range(0, 2))
                0: cv = 64'd0;
                1: cv = 64'($urandom_range(1, 6));
                default: cv = {32'($urandom), 32'($urandom)};
            endcase
            run_flv(cv);
            run_ht(($urandom_range(0, 3) == 0) ? 64'd0 : {32'($urandom), 32'($urandom)},
                   $urandom_range(0, 6));
            run_cb();
            run_tl();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
